// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory reader feeding a word queue that
// presents one- or two-word instruction bundles. Define FETCH_PREFETCH_EN for a 4-deep prefetching queue.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] instruction,
  output logic [15:0] imm_word,
  output logic [15:0] instr_pc
);

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH    = 4;
  localparam bit PREFETCH = 1'b1;
`else
  localparam int DEPTH    = 2;
  localparam bit PREFETCH = 1'b0;
`endif
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t        state, state_nxt;
  logic [15:0]   q [DEPTH];
  logic [PW-1:0] rd_ptr, rd_nxt, wr_ptr, head2_ptr;
  logic [CW-1:0] count, count_nxt, count_pop, pop_n;
  logic [15:0]   fetch_addr, fetch_nxt, addr_r, head_pc, redirect_al, head_nxt;
  logic          head_two, bundle_ok, fire, wr_en, valid_nxt, room, gate;

  assign redirect_al = redirect_pc & 16'hFFFE;
  assign head_two    = q[rd_ptr][15];
  assign head2_ptr   = rd_ptr + PW'(1);
  assign wr_ptr      = rd_ptr + count[PW-1:0];
  assign bundle_ok   = (count != '0) && (!head_two || count >= CW'(2));
  assign fire        = bundle_ok && out_ready && !redirect;
  assign pop_n       = fire ? (head_two ? CW'(2) : CW'(1)) : '0;
  assign wr_en       = (state == REQ) && mem_ack && !redirect;
  assign count_pop   = count - pop_n;
  assign rd_nxt      = rd_ptr + pop_n[PW-1:0];
  assign count_nxt   = redirect ? '0 : count_pop + CW'(wr_en);
  assign fetch_nxt   = redirect ? redirect_al :
                       ((state == REQ) && mem_ack) ? fetch_addr + 16'd2 : fetch_addr;

  // Look ahead at next cycle's queue so the non-prefetch build never requests
  // while a complete bundle will be sitting at the head.
  assign head_nxt  = (count_pop == '0) ? mem_data : q[rd_nxt];
  assign valid_nxt = (count_nxt != '0) && (!head_nxt[15] || count_nxt >= CW'(2));
  assign room      = count_nxt < CW'(DEPTH);
  assign gate      = PREFETCH || !valid_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (room && gate) state_nxt = REQ;
      REQ: begin
        if (redirect)     state_nxt = mem_ack ? IDLE : DISCARD;
        else if (mem_ack) state_nxt = (room && gate) ? REQ : IDLE;
      end
      DISCARD: if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req     = (state != IDLE);
    mem_addr    = addr_r;
    out_valid   = bundle_ok;
    instruction = bundle_ok ? q[rd_ptr] : 16'h0000;
    imm_word    = (bundle_ok && head_two) ? q[head2_ptr] : 16'h0000;
    instr_pc    = head_pc;
  end

  // Request address is latched on issue so it stays put through DISCARD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      rd_ptr     <= '0;
      fetch_addr <= 16'h0000;
      addr_r     <= 16'h0000;
      head_pc    <= 16'h0000;
      for (int i = 0; i < DEPTH; i++) q[i] <= 16'h0000;
    end else begin
      count      <= count_nxt;
      rd_ptr     <= rd_nxt;
      fetch_addr <= fetch_nxt;
      if (wr_en) q[wr_ptr] <= mem_data;
      if (state_nxt == REQ && (state != REQ || mem_ack)) addr_r <= fetch_nxt;
      if (redirect)  head_pc <= redirect_al;
      else if (fire) head_pc <= head_pc + (head_two ? 16'd4 : 16'd2);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory responder, a vector
// table of small programs, and hand sequences for stall, redirect-in-flight and async reset.
module tb_fetch_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_req, mem_ack = 1'b0, redirect = 1'b0, out_valid, out_ready = 1'b0;
  logic [15:0] mem_addr, mem_data = 16'h0000, redirect_pc = 16'h0000;
  logic [15:0] instruction, imm_word, instr_pc;
  logic [15:0] mem [0:32767];
  logic [15:0] bi, bm, bp;
  int checks = 0, errors = 0;
  int lat = 1, wait_cnt = 0, region_acks = 0;

`ifdef FETCH_PREFETCH_EN
  localparam int STALL_WORDS = 4;
`else
  localparam int STALL_WORDS = 1;
`endif

  typedef struct packed {
    logic [15:0] pc, w0, w1, w2, w3;
    logic [15:0] i0, m0, p0, i1, m1, p1;
  } vec_t;
  vec_t vecs [5];

  fetch_unit dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .instruction(instruction), .imm_word(imm_word), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  // memory: acks 'lat' cycles after a request first appears
  always @(negedge clk) begin
    if (rst || !mem_req) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = 1;
    end else if (wait_cnt >= lat) begin
      mem_ack  = 1'b1;
      mem_data = mem[mem_addr[15:1]];
      if (mem_addr >= 16'h0200 && mem_addr < 16'h0210) region_acks++;
    end else begin
      wait_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic get_bundle(input string name, output logic [15:0] i, output logic [15:0] m,
                            output logic [15:0] p);
    bit found = 1'b0;
    i = 16'hxxxx; m = 16'hxxxx; p = 16'hxxxx;
    for (int n = 0; n < 60 && !found; n++) begin
      tick;
      if (out_valid === 1'b1) found = 1'b1;
    end
    if (found) begin
      i = instruction; m = imm_word; p = instr_pc;
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: timeout got out_valid=%b expected 1", name, out_valid);
    end
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    tick;
    redirect = 1'b1;
    redirect_pc = pc;
    tick;
    redirect = 1'b0;
  endtask

  initial begin
    bit seen;
    logic [14:0] base;
    for (int k = 0; k < 32768; k++) mem[k] = 16'h0000;
    vecs[0] = '{16'h0000, 16'h0102, 16'h0304, 16'h0000, 16'h0000,
                16'h0102, 16'h0000, 16'h0000, 16'h0304, 16'h0000, 16'h0002};
    vecs[1] = '{16'h0000, 16'h8A01, 16'h1234, 16'h0056, 16'h0000,
                16'h8A01, 16'h1234, 16'h0000, 16'h0056, 16'h0000, 16'h0004};
    vecs[2] = '{16'hFFFE, 16'h0001, 16'h0002, 16'h0000, 16'h0000,
                16'h0001, 16'h0000, 16'hFFFE, 16'h0002, 16'h0000, 16'h0000};
    vecs[3] = '{16'h0021, 16'h7FFF, 16'hFFFF, 16'hABCD, 16'h0000,
                16'h7FFF, 16'h0000, 16'h0020, 16'hFFFF, 16'hABCD, 16'h0022};
    vecs[4] = '{16'h0100, 16'h8000, 16'h0000, 16'h8001, 16'h0005,
                16'h8000, 16'h0000, 16'h0100, 16'h8001, 16'h0005, 16'h0104};

    // reset values, first request, minimum latency
    mem[0] = 16'h0102;
    mem[1] = 16'h0304;
    tick;
    chk("rst mem_req", {15'd0, mem_req}, 16'h0000);
    chk("rst mem_addr", mem_addr, 16'h0000);
    chk("rst out_valid", {15'd0, out_valid}, 16'h0000);
    chk("rst instruction", instruction, 16'h0000);
    chk("rst imm_word", imm_word, 16'h0000);
    chk("rst instr_pc", instr_pc, 16'h0000);
    tick;
    rst = 1'b0;
    tick;
    chk("first mem_req", {15'd0, mem_req}, 16'h0001);
    chk("first mem_addr", mem_addr, 16'h0000);
    tick;
    chk("ack cycle mem_ack", {15'd0, mem_ack}, 16'h0001);
    chk("ack cycle out_valid", {15'd0, out_valid}, 16'h0000);
    tick;
    chk("latency out_valid", {15'd0, out_valid}, 16'h0001);
    chk("latency instruction", instruction, 16'h0102);
    chk("latency instr_pc", instr_pc, 16'h0000);

    // program table
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      base = vecs[v].pc[15:1];
      mem[base]          = vecs[v].w0;
      mem[base + 15'd1]  = vecs[v].w1;
      mem[base + 15'd2]  = vecs[v].w2;
      mem[base + 15'd3]  = vecs[v].w3;
      do_redirect(vecs[v].pc);
      chk($sformatf("vec%0d valid after redirect", v), {15'd0, out_valid}, 16'h0000);
      get_bundle($sformatf("vec%0d b0", v), bi, bm, bp);
      chk($sformatf("vec%0d b0 instr", v), bi, vecs[v].i0);
      chk($sformatf("vec%0d b0 imm", v), bm, vecs[v].m0);
      chk($sformatf("vec%0d b0 pc", v), bp, vecs[v].p0);
      get_bundle($sformatf("vec%0d b1", v), bi, bm, bp);
      chk($sformatf("vec%0d b1 instr", v), bi, vecs[v].i1);
      chk($sformatf("vec%0d b1 imm", v), bm, vecs[v].m1);
      chk($sformatf("vec%0d b1 pc", v), bp, vecs[v].p1);
    end

    // decoder stall: fetch stops once the queue (or a complete bundle) fills
    for (int k = 0; k < 8; k++) mem[16'h0100 + k] = 16'h0011 + 16'(k);
    out_ready = 1'b0;
    region_acks = 0;
    do_redirect(16'h0200);
    get_bundle("stall first", bi, bm, bp);
    for (int c = 0; c < 12; c++) begin
      tick;
      chk($sformatf("stall c%0d valid", c), {15'd0, out_valid}, 16'h0001);
      chk($sformatf("stall c%0d instr", c), instruction, 16'h0011);
      chk($sformatf("stall c%0d pc", c), instr_pc, 16'h0200);
    end
    chk("stall words fetched", 16'(region_acks), 16'(STALL_WORDS));
    chk("stall mem_req", {15'd0, mem_req}, 16'h0000);
    out_ready = 1'b1;
    get_bundle("stall resume", bi, bm, bp);
    chk("stall resume instr", bi, 16'h0012);
    chk("stall resume pc", bp, 16'h0202);

    // redirect while the request to 0x0006 is outstanding
    lat = 3;
    for (int k = 0; k < 16; k++) mem[k] = 16'h0A00 + 16'(k);
    mem[3] = 16'h0BAD;
    mem[16'h0020] = 16'h0C40;
    mem[16'h0021] = 16'h0C42;
    do_redirect(16'h0000);
    seen = 1'b0;
    for (int n = 0; n < 80 && !seen; n++) begin
      if (mem_req === 1'b1 && mem_addr === 16'h0006) seen = 1'b1;
      else tick;
    end
    chk("reach addr 6", {15'd0, seen}, 16'h0001);
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    tick;
    redirect = 1'b0;
    chk("discard valid", {15'd0, out_valid}, 16'h0000);
    chk("discard mem_req", {15'd0, mem_req}, 16'h0001);
    chk("discard addr held", mem_addr, 16'h0006);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick;
      if (mem_req === 1'b1 && mem_addr !== 16'h0006) seen = 1'b1;
    end
    chk("post discard req", {15'd0, seen}, 16'h0001);
    chk("post discard addr", mem_addr, 16'h0040);
    get_bundle("redir b0", bi, bm, bp);
    chk("redir b0 instr", bi, 16'h0C40);
    chk("redir b0 pc", bp, 16'h0040);
    get_bundle("redir b1", bi, bm, bp);
    chk("redir b1 instr", bi, 16'h0C42);
    chk("redir b1 pc", bp, 16'h0042);

    // asynchronous reset with a bundle waiting and requests in flight
    lat = 4;
    mem[0] = 16'h0111;
    mem[1] = 16'h0222;
    out_ready = 1'b0;
    do_redirect(16'h0000);
    get_bundle("pre-reset", bi, bm, bp);
    chk("pre-reset instr", bi, 16'h0111);
    #2;
    rst = 1'b1;
    #1;
    chk("async out_valid", {15'd0, out_valid}, 16'h0000);
    chk("async mem_req", {15'd0, mem_req}, 16'h0000);
    chk("async instruction", instruction, 16'h0000);
    chk("async mem_addr", mem_addr, 16'h0000);
    tick;
    rst = 1'b0;
    tick;
    chk("rerelease mem_req", {15'd0, mem_req}, 16'h0001);
    chk("rerelease mem_addr", mem_addr, 16'h0000);
    out_ready = 1'b1;
    get_bundle("post-reset b0", bi, bm, bp);
    chk("post-reset b0 instr", bi, 16'h0111);
    chk("post-reset b0 pc", bp, 16'h0000);
    get_bundle("post-reset b1", bi, bm, bp);
    chk("post-reset b1 instr", bi, 16'h0222);
    chk("post-reset b1 pc", bp, 16'h0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
